// File: rtl/pipeline_run_controller.sv
// Run/step/drain sequencer for the five-stage pipeline, driven by the UART debug interface.
// Optional run-mode watchdog is compiled in when RUN_WATCHDOG_EN is defined.
module pipeline_run_controller #(
  parameter int unsigned DRAIN_CYCLES    = 4,
  parameter int unsigned CYCLE_CNT_WIDTH = 32,
  parameter logic [31:0] WATCHDOG_LIMIT  = 32'd100000
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic [1:0]                 i_exec_mode,
  input  logic                       i_step,
  input  logic                       i_halt_decoded,
  output logic                       o_pc_enable,
  output logic                       o_pipe_enable,
  output logic                       o_program_finished,
  output logic                       o_timeout,
  output logic                       o_busy,
  output logic [CYCLE_CNT_WIDTH-1:0] o_cycle_count
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    RUN       = 3'd1,
    DRAIN     = 3'd2,
    STEP_WAIT = 3'd3,
    STEP_EXEC = 3'd4,
    DONE      = 3'd5,
    RELEASE   = 3'd6
  } state_t;

  localparam int unsigned DRAIN_W = $clog2(DRAIN_CYCLES + 1);
  localparam logic [DRAIN_W-1:0] DRAIN_LOAD = DRAIN_W'(DRAIN_CYCLES);
  localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
  localparam logic [CYCLE_CNT_WIDTH-1:0] CNT_ONE = CYCLE_CNT_WIDTH'(1);
  localparam logic [CYCLE_CNT_WIDTH-1:0] CNT_MAX = {CYCLE_CNT_WIDTH{1'b1}};

  state_t                     state_r, next_state_s;
  logic [DRAIN_W-1:0]         drain_r, drain_nxt_s;
  logic                       halt_flag_r, halt_flag_nxt_s;
  logic                       timeout_r, timeout_nxt_s;
  logic                       step_prev_r;
  logic                       count_clr_s;
  logic [CYCLE_CNT_WIDTH-1:0] count_r, count_nxt_s;
  logic                       pc_enable_r, pipe_enable_r, finished_r, busy_r;
  logic                       pc_nxt_s, pipe_nxt_s;
  logic                       run_req_s, step_req_s, stop_req_s, step_rise_s, wd_hit_s;

  // Mode 10 is reserved and behaves like 00, so bit 0 alone marks a stop request.
  assign run_req_s   = (i_exec_mode == 2'b01);
  assign step_req_s  = (i_exec_mode == 2'b11);
  assign stop_req_s  = ~i_exec_mode[0];
  // A held step request only counts once, on its rising edge.
  assign step_rise_s = i_step & ~step_prev_r;

`ifdef RUN_WATCHDOG_EN
  localparam logic [CYCLE_CNT_WIDTH-1:0] WD_LIMIT = CYCLE_CNT_WIDTH'(WATCHDOG_LIMIT);
  assign wd_hit_s = (count_r >= WD_LIMIT);
`else
  logic unused_wd_limit_s;
  assign unused_wd_limit_s = ^WATCHDOG_LIMIT;
  assign wd_hit_s = 1'b0;
`endif

  // Next-state, drain counter, halt flag and timeout decisions.
  always_comb begin
    next_state_s    = state_r;
    drain_nxt_s     = drain_r;
    halt_flag_nxt_s = halt_flag_r;
    timeout_nxt_s   = timeout_r;
    count_clr_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (run_req_s || step_req_s) begin
          next_state_s    = run_req_s ? RUN : STEP_WAIT;
          count_clr_s     = 1'b1;
          timeout_nxt_s   = 1'b0;
          halt_flag_nxt_s = 1'b0;
        end else begin
          next_state_s = IDLE;
        end
      end
      RUN: begin
        if (stop_req_s) begin
          next_state_s = IDLE;
        end else if (wd_hit_s) begin
          next_state_s  = DONE;
          timeout_nxt_s = 1'b1;
        end else if (i_halt_decoded) begin
          next_state_s = DRAIN;
          drain_nxt_s  = DRAIN_LOAD;
        end else begin
          next_state_s = RUN;
        end
      end
      DRAIN: begin
        if (stop_req_s) begin
          next_state_s = IDLE;
        end else if (wd_hit_s) begin
          next_state_s  = DONE;
          timeout_nxt_s = 1'b1;
        end else begin
          drain_nxt_s  = drain_r - DRAIN_ONE;
          next_state_s = (drain_r == DRAIN_ONE) ? DONE : DRAIN;
        end
      end
      STEP_WAIT: begin
        if (stop_req_s) begin
          next_state_s = IDLE;
        end else if (step_rise_s) begin
          next_state_s = STEP_EXEC;
        end else begin
          next_state_s = STEP_WAIT;
        end
      end
      STEP_EXEC: begin
        // Once halted, every further step retires one older instruction.
        if (halt_flag_r) begin
          drain_nxt_s  = drain_r - DRAIN_ONE;
          next_state_s = (drain_r == DRAIN_ONE) ? DONE : STEP_WAIT;
        end else if (i_halt_decoded) begin
          halt_flag_nxt_s = 1'b1;
          drain_nxt_s     = DRAIN_LOAD;
          next_state_s    = STEP_WAIT;
        end else begin
          next_state_s = STEP_WAIT;
        end
      end
      DONE: begin
        next_state_s = RELEASE;
      end
      RELEASE: begin
        if (stop_req_s) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = RELEASE;
        end
      end
      default: begin
        next_state_s = IDLE;
      end
    endcase
  end

  // Output strobes and cycle counter for the upcoming cycle; the count includes that cycle.
  always_comb begin
    pipe_nxt_s = (next_state_s == RUN) || (next_state_s == DRAIN) || (next_state_s == STEP_EXEC);
    pc_nxt_s   = (next_state_s == RUN) || ((next_state_s == STEP_EXEC) && !halt_flag_nxt_s);
    if (count_clr_s) begin
      count_nxt_s = pipe_nxt_s ? CNT_ONE : {CYCLE_CNT_WIDTH{1'b0}};
    end else if (pipe_nxt_s && (count_r != CNT_MAX)) begin
      count_nxt_s = count_r + CNT_ONE;
    end else begin
      count_nxt_s = count_r;
    end
  end

  // State and registered outputs.
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_r       <= IDLE;
      drain_r       <= {DRAIN_W{1'b0}};
      halt_flag_r   <= 1'b0;
      timeout_r     <= 1'b0;
      step_prev_r   <= 1'b0;
      count_r       <= {CYCLE_CNT_WIDTH{1'b0}};
      pc_enable_r   <= 1'b0;
      pipe_enable_r <= 1'b0;
      finished_r    <= 1'b0;
      busy_r        <= 1'b0;
    end else begin
      state_r       <= next_state_s;
      drain_r       <= drain_nxt_s;
      halt_flag_r   <= halt_flag_nxt_s;
      timeout_r     <= timeout_nxt_s;
      step_prev_r   <= i_step;
      count_r       <= count_nxt_s;
      pc_enable_r   <= pc_nxt_s;
      pipe_enable_r <= pipe_nxt_s;
      finished_r    <= (next_state_s == DONE);
      busy_r        <= (next_state_s != IDLE);
    end
  end

  assign o_pc_enable        = pc_enable_r;
  assign o_pipe_enable      = pipe_enable_r;
  assign o_program_finished = finished_r;
  assign o_timeout          = timeout_r;
  assign o_busy             = busy_r;
  assign o_cycle_count      = count_r;

endmodule

// File: tb/tb_pipeline_run_controller.sv
// Self-checking bench for pipeline_run_controller: behavioural model compared every cycle,
// plus hand-computed totals for the documented scenarios.
module tb_pipeline_run_controller;

  localparam int DRAIN = 4;
  localparam int CW    = 5;
  localparam int LIM   = 20;
  localparam int CMAX  = 31;
`ifdef RUN_WATCHDOG_EN
  localparam bit WD = 1'b1;
`else
  localparam bit WD = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          step = 1'b0;
  logic          halt = 1'b0;
  logic          pc_en, pipe_en, fin, tmo, busy;
  logic [CW-1:0] cnt;

  int checks = 0;
  int failures = 0;
  int n_pc = 0, n_pipe = 0, n_fin = 0;

  pipeline_run_controller #(
    .DRAIN_CYCLES(DRAIN), .CYCLE_CNT_WIDTH(CW), .WATCHDOG_LIMIT(32'd20)
  ) dut (
    .i_clk(clk), .i_reset_n(rst_n), .i_exec_mode(mode), .i_step(step),
    .i_halt_decoded(halt), .o_pc_enable(pc_en), .o_pipe_enable(pipe_en),
    .o_program_finished(fin), .o_timeout(tmo), .o_busy(busy), .o_cycle_count(cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: activity kind (0 none, 1 continuous, 2 stepwise), drain remaining,
  // finish pulse and post-finish hold, predicting the outputs of the coming cycle.
  int m_kind, m_drain, m_left, m_count;
  bit m_halted, m_hold, m_fin, m_exec, m_to, m_prev_step;
  bit e_pc, e_pipe, e_busy;

  always @(posedge clk or negedge rst_n) begin
    bit stop, rise, finish;
    if (!rst_n) begin
      m_kind = 0; m_drain = 0; m_left = 0; m_count = 0;
      m_halted = 0; m_hold = 0; m_fin = 0; m_exec = 0; m_to = 0; m_prev_step = 0;
      e_pc = 0; e_pipe = 0; e_busy = 0;
    end else begin
      stop = (mode[0] == 1'b0);
      rise = step && !m_prev_step;
      m_prev_step = step;
      finish = 0;
      if (m_fin) begin
        m_fin = 0; m_hold = 1;
      end else if (m_hold) begin
        if (stop) m_hold = 0;
      end else if (m_exec) begin
        m_exec = 0;
        if (m_halted) begin
          m_left--;
          if (m_left == 0) finish = 1;
        end else if (halt) begin
          m_halted = 1; m_left = DRAIN;
        end
      end else if (m_kind == 0) begin
        if (mode == 2'b01 || mode == 2'b11) begin
          m_kind = (mode == 2'b01) ? 1 : 2;
          m_count = 0; m_to = 0; m_halted = 0; m_drain = 0;
        end
      end else if (stop) begin
        m_kind = 0; m_drain = 0;
      end else if (m_kind == 1) begin
        if (WD && m_count >= LIM) begin
          finish = 1; m_to = 1;
        end else if (m_drain > 0) begin
          m_drain--;
          if (m_drain == 0) finish = 1;
        end else if (halt) begin
          m_drain = DRAIN;
        end
      end else if (rise) begin
        m_exec = 1;
      end
      if (finish) begin
        m_fin = 1; m_kind = 0; m_drain = 0;
      end
      e_pipe = (m_kind == 1) || m_exec;
      e_pc   = (m_kind == 1 && m_drain == 0) || (m_exec && !m_halted);
      e_busy = (m_kind != 0) || m_fin || m_hold;
      if (e_pipe && m_count < CMAX) m_count++;
    end
  end

  // Per-cycle comparison against the model, plus activity totals for the scenarios.
  always @(negedge clk) begin
    chk("pc_enable", pc_en, e_pc);
    chk("pipe_enable", pipe_en, e_pipe);
    chk("program_finished", fin, m_fin);
    chk("busy", busy, e_busy);
    chk("timeout", tmo, m_to);
    chk("cycle_count", cnt, m_count);
    if (pc_en) n_pc++;
    if (pipe_en) n_pipe++;
    if (fin) n_fin++;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic clr_tot();
    n_pc = 0; n_pipe = 0; n_fin = 0;
  endtask

  initial begin
    tick(2);
    chk("reset_pipe", pipe_en, 0);
    chk("reset_busy", busy, 0);
    chk("reset_count", cnt, 0);
    rst_n = 1'b1;
    tick(2);

    // Continuous run, halt in the 10th enabled cycle, then mode held at 01.
    clr_tot();
    mode = 2'b01;
    tick(10);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    tick(15);
    chk("run_pc_cycles", n_pc, 10);
    chk("run_pipe_cycles", n_pipe, 14);
    chk("run_fin_pulses", n_fin, 1);
    chk("run_count", cnt, 14);
    chk("release_hold_busy", busy, 1);
    mode = 2'b00;
    tick(2);
    chk("release_to_idle", busy, 0);

    // Stepwise: halt on the 4th step, four more steps to drain.
    mode = 2'b11;
    tick(2);
    clr_tot();
    for (int s = 1; s <= 8; s++) begin
      step = 1'b1;
      tick(1);
      step = 1'b0;
      halt = (s == 4);
      tick(1);
      halt = 1'b0;
      tick(1);
    end
    tick(1);
    chk("step_pipe_cycles", n_pipe, 8);
    chk("step_pc_cycles", n_pc, 4);
    chk("step_fin_pulses", n_fin, 1);
    chk("step_count", cnt, 8);
    mode = 2'b00;
    tick(2);

    // Step request held for three cycles yields one enabled cycle.
    mode = 2'b11;
    tick(2);
    clr_tot();
    step = 1'b1;
    tick(3);
    step = 1'b0;
    tick(3);
    chk("held_step_cycles", n_pipe, 1);
    chk("held_step_waiting", busy, 1);
    mode = 2'b10;
    tick(2);
    chk("reserved_mode_abort", busy, 0);

    // Abort during drain, then abort coinciding with halt.
    clr_tot();
    mode = 2'b01;
    tick(3);
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    tick(2);
    mode = 2'b00;
    tick(4);
    mode = 2'b01;
    tick(3);
    mode = 2'b00;
    halt = 1'b1;
    tick(1);
    halt = 1'b0;
    tick(3);
    chk("abort_no_fin", n_fin, 0);
    chk("abort_idle", busy, 0);

    // Asynchronous reset in the middle of a run.
    mode = 2'b01;
    tick(5);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_pc", pc_en, 0);
    chk("async_rst_pipe", pipe_en, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_count", cnt, 0);
    mode = 2'b00;
    tick(2);
    rst_n = 1'b1;
    tick(2);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_count", cnt, 0);

    // Long continuous run without halt: watchdog or saturation.
    clr_tot();
    mode = 2'b01;
    tick(41);
    if (WD) begin
      chk("wd_pipe_cycles", n_pipe, 20);
      chk("wd_fin_pulses", n_fin, 1);
      chk("wd_timeout", tmo, 1);
      chk("wd_count", cnt, 20);
    end else begin
      chk("nowd_pipe_cycles", n_pipe, 40);
      chk("nowd_fin_pulses", n_fin, 0);
      chk("nowd_timeout", tmo, 0);
      chk("nowd_count_saturated", cnt, 31);
    end
    mode = 2'b00;
    tick(3);
    chk("timeout_holds_in_idle", tmo, WD ? 1 : 0);
    mode = 2'b11;
    tick(2);
    chk("timeout_cleared_on_start", tmo, 0);
    mode = 2'b00;
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pipeline_run_controller.md
# pipeline_run_controller

Sequences execution of the five-stage pipeline on behalf of the UART debug interface. It turns the 2-bit execution-mode request and the single-step pulse into per-cycle PC-advance and latch-enable strobes. It detects the halt instruction and drains the instructions already in flight, then returns a one-cycle program-finished pulse to the debug interface. A saturating cycle counter of enabled cycles is exported for the debug dump.

## Interface
- `DRAIN_CYCLES`, default 4: enabled cycles after halt decode needed to retire older in-flight instructions (≥1).
- `CYCLE_CNT_WIDTH`, default 32: width of the executed-cycle counter.
- `WATCHDOG_LIMIT`, default 32'd100000: run-cycle limit. Used only with `RUN_WATCHDOG_EN`.
- `i_clk`, in, 1: clock. All logic is on the rising edge.
- `i_reset_n`, in, 1: reset, asynchronous, active-low.
- `i_exec_mode`, in, 2: mode request. 00 = idle, 01 = continuous, 11 = stepwise, 10 = reserved and treated as 00.
- `i_step`, in, 1: single-step request pulse, used in stepwise mode.
- `i_halt_decoded`, in, 1: the halt instruction is in ID this cycle. Meaningful only when `o_pipe_enable` = 1.
- `o_pc_enable`, out, 1: PC/IF advance enable.
- `o_pipe_enable`, out, 1: enable for all inter-stage latches, the register file and the data memory write.
- `o_program_finished`, out, 1: one-cycle pulse when the program completes or is timed out.
- `o_timeout`, out, 1: the last completion was forced by the watchdog.
- `o_busy`, out, 1: the controller is in any state other than IDLE.
- `o_cycle_count`, out, `CYCLE_CNT_WIDTH`: number of cycles with `o_pipe_enable` = 1 since the last start.

## Operation
All outputs are registered. Reset values: every output is 0 and the state is IDLE.

States and transitions:
- **IDLE**
  - Both enables are 0.
  - mode 01 → RUN; mode 11 → STEP_WAIT.
  - On either exit, `o_cycle_count` and `o_timeout` are cleared and the halt flag is cleared.
- **RUN**
  - `o_pc_enable` = `o_pipe_enable` = 1.
  - `i_halt_decoded` → DRAIN, with drain_cnt = `DRAIN_CYCLES`.
  - mode 00 or 10 → IDLE. This is an abort: no finished pulse is produced.
- **DRAIN**
  - `o_pc_enable` = 0, `o_pipe_enable` = 1, drain_cnt decrements each cycle.
  - After exactly `DRAIN_CYCLES` cycles → DONE.
  - mode 00 → IDLE (abort).
- **STEP_WAIT**
  - Both enables are 0.
  - `i_step` → STEP_EXEC.
  - mode 00 → IDLE.
- **STEP_EXEC**, lasts exactly one cycle:
  - `o_pipe_enable` = 1.
  - `o_pc_enable` = 1 if the halt flag is clear, else 0.
  - `i_halt_decoded` sets the halt flag and loads drain_cnt = `DRAIN_CYCLES`.
  - If the halt flag was already set on entry, drain_cnt decrements.
  - When drain_cnt reaches 0 → DONE; otherwise → STEP_WAIT.
- **DONE**
  - Both enables are 0, `o_program_finished` = 1 for this single cycle.
  - → RELEASE.
- **RELEASE**
  - Waits for mode 00 (or 10), then → IDLE.
  - This prevents an automatic restart while the debug interface still holds the previous mode.

Counter and mode rules:
- `o_cycle_count` increments on every cycle with `o_pipe_enable` = 1 and saturates at all-ones (no wrap).
- A mode change between 01 and 11 while busy is ignored. Only 00 aborts.
- `i_step` is ignored in every state except STEP_WAIT. A step pulse in STEP_EXEC is dropped, not queued.
- `i_halt_decoded` is ignored in DRAIN and when the halt flag is already set. A second halt does not restart the drain.

## Timing
- mode 01 sampled at edge N → enables high from cycle N+1.
- `i_step` sampled at edge N → `o_pipe_enable` high in cycle N+1 only.
- Halt in RUN sampled at edge N → `o_pc_enable` low from N+1 and `o_pipe_enable` high for cycles N+1 … N+`DRAIN_CYCLES`.
  - `o_program_finished` is high in cycle N+`DRAIN_CYCLES`+1.
- When an abort and a halt coincide, the abort wins.
- Reset mid-run clears all state immediately and asynchronously. The enables drop without waiting for a clock edge.

## Configuration
- `RUN_WATCHDOG_EN` defined:
  - In RUN or DRAIN, when `o_cycle_count` reaches `WATCHDOG_LIMIT`, the controller goes to DONE on the next edge and sets `o_timeout` = 1.
  - `o_timeout` holds until the next exit from IDLE.
  - The watchdog does not apply in stepwise mode.
- `RUN_WATCHDOG_EN` undefined:
  - No limit is applied and `o_timeout` is constant 0.
  - `WATCHDOG_LIMIT` is unused.

## Test plan
- Continuous run, halt asserted at the 10th enabled cycle, `DRAIN_CYCLES` = 4 → `o_pc_enable` high for 10 cycles, `o_pipe_enable` high for 14 cycles, finished pulse one cycle later, `o_cycle_count` = 14.
- Stepwise run: three `i_step` pulses then halt on the 4th step, followed by 4 more steps → each step gives exactly one enabled cycle; finished pulses after the 8th step; `o_cycle_count` = 8.
- `i_step` held high for 3 cycles in STEP_WAIT → exactly one enabled cycle, then STEP_WAIT again; the extra cycles are ignored.
- Mode returns to 00 during DRAIN → IDLE, no finished pulse. Mode held at 01 after DONE → stays in RELEASE with no restart until mode = 00.
- `i_reset_n` low mid-RUN → all outputs 0 asynchronously; after release the controller is in IDLE with counter 0.
- With `RUN_WATCHDOG_EN`, `WATCHDOG_LIMIT` = 20, no halt → finished pulse after 20 enabled cycles and `o_timeout` = 1. Without the macro → the run continues past cycle 20.
